nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that processes one 4-bit slice per clock through a single combinational 4-bit ripple slice and registers the inter-nibble carry between cycles. It sits upstream of the 4-bit adder slice, sequencing operand nibbles into it and collecting its sum and carry outputs. The result is a wide adder with small area, at the cost of WIDTH/4 cycles of latency. A valid/ready handshake is used on both input and output.

---
 rtl/adder_pkg.sv | 14 +
 rtl/adder_slice4.sv | 44 ++++
 rtl/nibble_serial_adder.sv | 142 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the nibble-serial adder: state encoding and slice width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_slice4.sv
// 4-bit ripple-carry slice built from single-bit full-adder cells.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the slice result is used.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder_slice4
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   // carry chain: c[0] is the slice carry-in, c[NIBBLE_W] the carry-out
   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes one nibble per clock through a single 4-bit slice; SIGNED_OVERFLOW_EN adds an Overflow flag.
// Latency: OutValid rises WIDTH/4 cycles after the accept edge; one operation per WIDTH/4+2 cycles at best.
// Backpressure: InReady only in IDLE; the result is held in DONE until OutReady.
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic             InputCarry,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] Output,
   output logic             OutputCarry,
   output logic             OutValid,
   input  logic             OutReady
`ifdef SIGNED_OVERFLOW_EN
   ,
   output logic             Overflow
`endif
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   state_t              state;
   state_t              next_state;
   logic [WIDTH-1:0]    a_sh;
   logic [WIDTH-1:0]    b_sh;
   logic [WIDTH-1:0]    sum_next;
   logic                carry;
   logic [CNT_W-1:0]    cnt;
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;
   logic                last_nibble;

   // the single arithmetic slice always works on the low nibble of the shifters
   adder_slice4 u_slice (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (b_sh[NIBBLE_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // new nibble enters at the top, so after NIBBLES shifts nibble 0 sits at the bottom
   if (NIBBLES == 1) begin : g_single
      assign sum_next = slice_sum;
   end else begin : g_multi
      assign sum_next = {slice_sum, Output[WIDTH-1:NIBBLE_W]};
   end

   assign last_nibble = (cnt == LAST_CNT);

   // handshake outputs decoded from registered state only
   assign InReady  = (state == IDLE);
   assign OutValid = (state == DONE);

   // state register
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state decode
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (InValid)     next_state = RUN;
         RUN:     if (last_nibble) next_state = DONE;
         DONE:    if (OutReady)    next_state = IDLE;
         default:                  next_state = IDLE;
      endcase
   end

   // operand capture, nibble shifting, carry chaining and result assembly
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         a_sh        <= '0;
         b_sh        <= '0;
         carry       <= 1'b0;
         cnt         <= '0;
         Output      <= '0;
         OutputCarry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (InValid) begin
                  a_sh  <= InputA;
                  b_sh  <= InputB;
                  carry <= InputCarry;
                  cnt   <= '0;
               end
            end
            RUN: begin
               Output <= sum_next;
               a_sh   <= a_sh >> NIBBLE_W;
               b_sh   <= b_sh >> NIBBLE_W;
               carry  <= slice_cout;
               cnt    <= cnt + 1'b1;
               if (last_nibble) begin
                  OutputCarry <= slice_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SIGNED_OVERFLOW_EN
   logic a_msb;
   logic b_msb;

   // operand sign bits kept from accept; flag set with the final nibble, dropped on consume
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         if (state == IDLE && InValid) begin
            a_msb <= InputA[WIDTH-1];
            b_msb <= InputB[WIDTH-1];
         end
         if (state == RUN && last_nibble) begin
            Overflow <= (a_msb == b_msb) && (slice_sum[NIBBLE_W-1] != a_msb);
         end else if (state == DONE && OutReady) begin
            Overflow <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16: vector table plus reset, backpressure and back-to-back sequences.
// Latency: expects OutValid 4 cycles after accept.
// Backpressure: holds OutReady low in DONE and checks the result is frozen.
module tb_nibble_serial_adder;

   logic        Clock;
   logic        ResetN;
   logic [15:0] InputA;
   logic [15:0] InputB;
   logic        InputCarry;
   logic        InValid;
   logic        InReady;
   logic [15:0] Output;
   logic        OutputCarry;
   logic        OutValid;
   logic        OutReady;
`ifdef SIGNED_OVERFLOW_EN
   logic        Overflow;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs [8];

   nibble_serial_adder #(.WIDTH(16)) dut (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .InputA      (InputA),
      .InputB      (InputB),
      .InputCarry  (InputCarry),
      .InValid     (InValid),
      .InReady     (InReady),
      .Output      (Output),
      .OutputCarry (OutputCarry),
      .OutValid    (OutValid),
      .OutReady    (OutReady)
`ifdef SIGNED_OVERFLOW_EN
      ,
      .Overflow    (Overflow)
`endif
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // present one operation and wait (bounded) for OutValid; lat counts cycles after the accept edge
   task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic cin, output int lat);
      int w;
      w = 0;
      @(negedge Clock);
      while (!InReady && w < 20) begin
         @(negedge Clock);
         w++;
      end
      check("in_ready_wait", {31'd0, InReady}, 32'd1);
      InputA     = a;
      InputB     = b;
      InputCarry = cin;
      InValid    = 1'b1;
      @(negedge Clock);
      InValid = 1'b0;
      lat = 0;
      while (!OutValid && lat < 20) begin
         @(negedge Clock);
         lat++;
      end
   endtask

   task automatic consume();
      OutReady = 1'b1;
      @(negedge Clock);
      OutReady = 1'b0;
      check("consume_out_valid", {31'd0, OutValid}, 32'd0);
      check("consume_in_ready", {31'd0, InReady}, 32'd1);
   endtask

   initial begin
      int   lat;
      logic seen_valid;
      int   nacc;
      int   nres;
      int   acc_t [2];
      logic [15:0] res [2];

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
      vecs[7] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0};

      ResetN     = 1'b0;
      InputA     = '0;
      InputB     = '0;
      InputCarry = 1'b0;
      InValid    = 1'b0;
      OutReady   = 1'b0;

      // reset state
      repeat (3) @(negedge Clock);
      check("rst_output", {16'd0, Output}, 32'd0);
      check("rst_carry", {31'd0, OutputCarry}, 32'd0);
      check("rst_out_valid", {31'd0, OutValid}, 32'd0);
`ifdef SIGNED_OVERFLOW_EN
      check("rst_overflow", {31'd0, Overflow}, 32'd0);
`endif
      ResetN = 1'b1;
      @(negedge Clock);
      check("rst_in_ready", {31'd0, InReady}, 32'd1);

      // table-driven vectors
      for (int i = 0; i < 8; i++) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
         check($sformatf("vec%0d_latency", i), lat, 32'd4);
         check($sformatf("vec%0d_sum", i), {16'd0, Output}, {16'd0, vecs[i].sum});
         check($sformatf("vec%0d_cout", i), {31'd0, OutputCarry}, {31'd0, vecs[i].cout});
         check($sformatf("vec%0d_in_ready_done", i), {31'd0, InReady}, 32'd0);
`ifdef SIGNED_OVERFLOW_EN
         check($sformatf("vec%0d_overflow", i), {31'd0, Overflow}, {31'd0, vecs[i].ovf});
`endif
         consume();
`ifdef SIGNED_OVERFLOW_EN
         check($sformatf("vec%0d_overflow_cleared", i), {31'd0, Overflow}, 32'd0);
`endif
      end

      // backpressure: result frozen for 5 cycles, stray InValid ignored
      apply(16'h1234, 16'h4321, 1'b0, lat);
      check("bp_latency", lat, 32'd4);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            InputA  = 16'hAAAA;
            InputB  = 16'hAAAA;
            InValid = 1'b1;
         end
         if (i == 2) InValid = 1'b0;
         @(negedge Clock);
         check("bp_output", {16'd0, Output}, 32'h5555);
         check("bp_carry", {31'd0, OutputCarry}, 32'd0);
         check("bp_out_valid", {31'd0, OutValid}, 32'd1);
         check("bp_in_ready", {31'd0, InReady}, 32'd0);
      end
      consume();
      apply(16'h1111, 16'h2222, 1'b0, lat);
      check("bp_next_latency", lat, 32'd4);
      check("bp_next_sum", {16'd0, Output}, 32'h3333);
      consume();

      // reset during the second RUN cycle
      @(negedge Clock);
      InputA     = 16'h0F0F;
      InputB     = 16'h0101;
      InputCarry = 1'b0;
      InValid    = 1'b1;
      @(negedge Clock);
      InValid = 1'b0;
      @(negedge Clock);
      ResetN = 1'b0;
      #1;
      check("abort_output", {16'd0, Output}, 32'd0);
      check("abort_carry", {31'd0, OutputCarry}, 32'd0);
      check("abort_out_valid", {31'd0, OutValid}, 32'd0);
      seen_valid = 1'b0;
      repeat (2) begin
         @(negedge Clock);
         seen_valid = seen_valid | OutValid;
      end
      ResetN = 1'b1;
      @(negedge Clock);
      check("abort_in_ready", {31'd0, InReady}, 32'd1);
      repeat (8) begin
         @(negedge Clock);
         seen_valid = seen_valid | OutValid;
      end
      check("abort_no_valid", {31'd0, seen_valid}, 32'd0);
      apply(16'h0002, 16'h0003, 1'b0, lat);
      check("abort_next_latency", lat, 32'd4);
      check("abort_next_sum", {16'd0, Output}, 32'h0005);
      check("abort_next_cout", {31'd0, OutputCarry}, 32'd0);
      consume();

      // back-to-back with InValid and OutReady held high
      @(negedge Clock);
      InputA     = 16'h1234;
      InputB     = 16'h4321;
      InputCarry = 1'b0;
      InValid    = 1'b1;
      OutReady   = 1'b1;
      nacc = 0;
      nres = 0;
      acc_t[0] = 0;
      acc_t[1] = 0;
      res[0] = '0;
      res[1] = '0;
      for (int c = 0; c < 40 && nres < 2; c++) begin
         if (InValid && InReady && nacc < 2) begin
            acc_t[nacc] = c;
            nacc++;
         end
         if (OutValid) begin
            res[nres] = Output;
            nres++;
         end
         @(negedge Clock);
         if (nacc == 1) begin
            InputA = 16'h00FF;
            InputB = 16'h0F01;
         end
         if (nacc >= 2) InValid = 1'b0;
      end
      OutReady = 1'b0;
      InValid  = 1'b0;
      check("b2b_accepts", nacc, 32'd2);
      check("b2b_results", nres, 32'd2);
      check("b2b_spacing", acc_t[1] - acc_t[0], 32'd6);
      check("b2b_sum0", {16'd0, res[0]}, 32'h5555);
      check("b2b_sum1", {16'd0, res[1]}, 32'h1000);
      @(negedge Clock);
      check("b2b_idle", {31'd0, InReady}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
